reg8x4_scan_ctrl: RTL and testbench

REG8X4_SCAN_CTRL -- requirements
Module: reg8x4_scan_ctrl

---
 rtl/scan_pkg.sv | 12 +
 rtl/lowest_set_enc.sv | 17 +
 rtl/reg8x4_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_reg8x4_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared constants and FSM encoding for the 8-entry scan controller.
package scan_pkg;
  localparam int DW = 4;
  localparam int N  = 8;
  localparam int SW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/lowest_set_enc.sv
// Combinational priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_set_enc
  import scan_pkg::*;
(
  input  logic [N-1:0]  req_i,
  output logic [SW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = SW'(i);
    end
  end

  assign any_o = |req_i;
endmodule

// File: rtl/reg8x4_scan_ctrl.sv
// Eight-entry register array with a mask-driven scan that streams selected entries in ascending order.
// One item per cycle under valid/ready; out_data and s hold while the consumer stalls.
module reg8x4_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DW = scan_pkg::DW,
  parameter int N  = scan_pkg::N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [N-1:0]  mask,
  output logic [DW-1:0] A0,
  output logic [DW-1:0] A1,
  output logic [DW-1:0] A2,
  output logic [DW-1:0] A3,
  output logic [DW-1:0] A4,
  output logic [DW-1:0] A5,
  output logic [DW-1:0] A6,
  output logic [DW-1:0] A7,
  output logic [2:0]    s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);
  state_t        state_q, state_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [2:0]    s_q, s_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] mem_q [N];

  logic [N-1:0]  rem_clr;
  logic [N-1:0]  enc_in;
  logic [2:0]    enc_idx;
  logic          enc_any;

  // In IDLE the encoder looks at the incoming mask; in SEND at what remains after the current item.
  assign rem_clr = rem_q & ~({{(N-1){1'b0}}, 1'b1} << s_q);
  assign enc_in  = (state_q == IDLE) ? mask : rem_clr;

  lowest_set_enc u_enc (
    .req_i (enc_in),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = enc_any ? SEND : DONE;
      SEND:    if (out_ready && !enc_any) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign done      = (state_q == DONE);

  // Capture reads mem_q before this edge's write lands, so a same-edge write is not seen.
  always_comb begin
    rem_d = rem_q;
    s_d   = s_q;
    dat_d = dat_q;
    if (state_q == IDLE && start && enc_any) begin
      rem_d = mask;
      s_d   = enc_idx;
      dat_d = mem_q[enc_idx];
    end else if (state_q == SEND && out_ready) begin
      rem_d = rem_clr;
      if (enc_any) begin
        s_d   = enc_idx;
        dat_d = mem_q[enc_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      s_q   <= '0;
      dat_q <= '0;
    end else begin
      rem_q <= rem_d;
      s_q   <= s_d;
      dat_q <= dat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign s        = s_q;
  assign out_data = dat_q;
  assign A0 = mem_q[0];
  assign A1 = mem_q[1];
  assign A2 = mem_q[2];
  assign A3 = mem_q[3];
  assign A4 = mem_q[4];
  assign A5 = mem_q[5];
  assign A6 = mem_q[6];
  assign A7 = mem_q[7];
endmodule

// File: tb/tb_reg8x4_scan_ctrl.sv
// Scoreboard bench for reg8x4_scan_ctrl: stimulus queues expected items/done pulses, a monitor checks them.
module tb_reg8x4_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       start;
  logic [7:0] mask;
  logic [3:0] A0, A1, A2, A3, A4, A5, A6, A7;
  logic [2:0] s;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
  logic       done;

  typedef struct {
    bit         is_done;
    logic [2:0] s;
    logic [3:0] d;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  reg8x4_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .mask(mask),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
    .s(s), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input string act, input string req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic [2:0] si, input logic [3:0] di, input int c);
    exp_t e;
    e.is_done = 1'b0; e.s = si; e.d = di; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.is_done = 1'b1; e.s = '0; e.d = '0; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic start_scan(input logic [7:0] m);
    start = 1'b1;
    mask  = m;
    tick();
    start = 1'b0;
    mask  = '0;
  endtask

  task automatic write(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Monitor: every handshake and every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_item", 1'b0, $sformatf("s=%0d d=%h", s, out_data), "no item");
        end else begin
          e = sb.pop_front();
          chk("item", !e.is_done && s == e.s && out_data == e.d && (e.cyc < 0 || cyc == e.cyc),
              $sformatf("item s=%0d d=%h cyc=%0d", s, out_data, cyc),
              e.is_done ? $sformatf("done at cyc=%0d", e.cyc)
                        : $sformatf("item s=%0d d=%h cyc=%0d", e.s, e.d, e.cyc));
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1'b0, $sformatf("done at cyc=%0d", cyc), "no done");
        end else begin
          e = sb.pop_front();
          chk("done", e.is_done && (e.cyc < 0 || cyc == e.cyc),
              $sformatf("done at cyc=%0d", cyc),
              e.is_done ? $sformatf("done at cyc=%0d", e.cyc)
                        : $sformatf("item s=%0d d=%h", e.s, e.d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; mask = '0; out_ready = 1'b1;
    #12;
    chk("reset_ctrl", {out_valid, busy, done} == 3'b000 && s == 3'd0 && out_data == 4'h0,
        $sformatf("v=%b b=%b d=%b s=%0d od=%h", out_valid, busy, done, s, out_data), "all zero");
    chk("reset_array", {A0, A1, A2, A3, A4, A5, A6, A7} == 32'h0,
        $sformatf("%h", {A0, A1, A2, A3, A4, A5, A6, A7}), "00000000");
    tick();
    rst_n = 1'b1;
    tick();

    // Scenario 1: sparse mask, streaming consumer
    for (int i = 0; i < 8; i++) write(3'(i), 4'(i));
    c = cyc;
    push_item(3'd0, 4'h0, c + 1);
    push_item(3'd2, 4'h2, c + 2);
    push_item(3'd5, 4'h5, c + 3);
    push_item(3'd7, 4'h7, c + 4);
    push_done(c + 5);
    start_scan(8'b1010_0101);
    repeat (6) tick();

    // Scenario 2: empty mask
    c = cyc;
    push_done(c + 1);
    start_scan(8'h00);
    repeat (3) tick();

    // Scenario 3: consumer stalls for five cycles
    out_ready = 1'b0;
    c = cyc;
    push_item(3'd0, 4'h0, -1);
    push_item(3'd1, 4'h1, c + 7);
    push_done(c + 8);
    start_scan(8'h03);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", out_valid && s == 3'd0 && out_data == 4'h0,
          $sformatf("v=%b s=%0d d=%h", out_valid, s, out_data), "v=1 s=0 d=0");
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();

    // Write landing on the same edge that captures the entry is not seen
    c = cyc;
    push_item(3'd2, 4'h2, c + 1);
    push_done(c + 2);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h9;
    start_scan(8'h04);
    wr_en = 1'b0;
    repeat (3) tick();

    // Scenario 4: writes during a held scan
    out_ready = 1'b0;
    push_item(3'd0, 4'h0, -1);
    push_item(3'd7, 4'hA, -1);
    push_done(-1);
    start_scan(8'h81);
    write(3'd7, 4'hA);
    write(3'd0, 4'hF);
    out_ready = 1'b1;
    repeat (4) tick();

    // Scenario 5: asynchronous reset mid-scan
    out_ready = 1'b0;
    start_scan(8'hFF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {out_valid, busy, done} == 3'b000 && s == 3'd0 && out_data == 4'h0,
        $sformatf("v=%b b=%b d=%b s=%0d od=%h", out_valid, busy, done, s, out_data), "all zero");
    chk("midreset_array", {A0, A1, A2, A3, A4, A5, A6, A7} == 32'h0,
        $sformatf("%h", {A0, A1, A2, A3, A4, A5, A6, A7}), "00000000");
    tick();
    rst_n = 1'b1;
    tick();
    write(3'd4, 4'h5);
    out_ready = 1'b1;
    c = cyc;
    push_item(3'd1, 4'h0, c + 1);
    push_item(3'd4, 4'h5, c + 2);
    push_done(c + 3);
    start_scan(8'h12);
    repeat (4) tick();

    // Scenario 6: start while busy is ignored
    write(3'd2, 4'hC);
    write(3'd3, 4'hD);
    c = cyc;
    push_item(3'd2, 4'hC, c + 1);
    push_item(3'd3, 4'hD, c + 2);
    push_done(c + 3);
    start_scan(8'h0C);
    chk("busy_high", busy == 1'b1, $sformatf("%b", busy), "1");
    start = 1'b1; mask = 8'hFF;
    tick();
    start = 1'b0; mask = '0;
    repeat (6) tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", sb.size() == 0, $sformatf("%0d pending", sb.size()), "0 pending");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
